// File: rtl/run_controller_if.sv
// Handshake bundle between a run controller and the host that launches and
// observes a core run; the slave side is the controller itself.
interface run_controller_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             start;
   logic [XLEN-1:0]  pc;
   logic             instr_retire;
   logic             ecall;
   logic             core_rst;
   logic             running;
   logic             done;
   logic [1:0]       status;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] retire_count;

   modport master (
      output start, pc, instr_retire, ecall,
      input  core_rst, running, done, status, cycle_count, retire_count
   );

   modport slave (
      input  start, pc, instr_retire, ecall,
      output core_rst, running, done, status, cycle_count, retire_count
   );
endinterface

// File: rtl/run_controller.sv
// Launches a core out of reset, counts run cycles and retired instructions,
// and stops the run on ecall, a pc stall, or a cycle timeout.
module run_controller #(
   parameter int XLEN        = 32,
   parameter int CNT_W       = 32,
   parameter int RST_HOLD    = 4,
   parameter int TIMEOUT     = 100000,
   parameter int HALT_STABLE = 16
) (
   input logic              clk,
   input logic              rst,
   run_controller_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      RUN,
      DONE
   } state_t;

   localparam logic [1:0] ST_NONE    = 2'b00;
   localparam logic [1:0] ST_ECALL   = 2'b01;
   localparam logic [1:0] ST_STALL   = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;

   localparam int STALL_W = (HALT_STABLE > 1) ? $clog2(HALT_STABLE) : 1;

   localparam logic [15:0]        HOLD_LAST    = 16'(RST_HOLD - 1);
   localparam logic [STALL_W-1:0] STALL_LAST   = STALL_W'(HALT_STABLE - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX      = '1;

   state_t             state;
   state_t             state_nx;
   logic [15:0]        hold_cnt;
   logic [STALL_W-1:0] stall_cnt;
   logic [XLEN-1:0]    prev_pc;
   logic               prev_valid;

   logic               stall_cond;
   logic               ecall_hit;
   logic               stall_hit;
   logic               timeout_hit;
   logic [1:0]         term_code;

   // prev_valid keeps the first RUN cycle from comparing against a stale pc.
   always_comb begin
      state_nx    = state;
      ecall_hit   = 1'b0;
      stall_hit   = 1'b0;
      timeout_hit = 1'b0;
      term_code   = ST_NONE;
      stall_cond  = prev_valid && !bus.instr_retire && (bus.pc == prev_pc);

      case (state)
         IDLE: begin
            if (bus.start) state_nx = HOLD;
         end
         HOLD: begin
            if (hold_cnt == HOLD_LAST) state_nx = RUN;
         end
         RUN: begin
            ecall_hit   = bus.ecall;
            stall_hit   = (HALT_STABLE != 0) && stall_cond && (stall_cnt == STALL_LAST);
            timeout_hit = (TIMEOUT != 0) && (bus.cycle_count == TIMEOUT_LAST);
            if (ecall_hit)        term_code = ST_ECALL;
            else if (stall_hit)   term_code = ST_STALL;
            else if (timeout_hit) term_code = ST_TIMEOUT;
            if (ecall_hit || stall_hit || timeout_hit) state_nx = DONE;
         end
         DONE: begin
            if (bus.start) state_nx = HOLD;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         bus.core_rst     <= 1'b1;
         bus.running      <= 1'b0;
         bus.done         <= 1'b0;
         bus.status       <= ST_NONE;
         bus.cycle_count  <= '0;
         bus.retire_count <= '0;
         hold_cnt         <= '0;
         stall_cnt        <= '0;
         prev_pc          <= '0;
         prev_valid       <= 1'b0;
      end else begin
         state        <= state_nx;
         bus.core_rst <= (state_nx != RUN);
         bus.running  <= (state_nx == RUN);
         bus.done     <= (state_nx == DONE);

         if ((state_nx == HOLD) && (state != HOLD)) begin
            bus.status       <= ST_NONE;
            bus.cycle_count  <= '0;
            bus.retire_count <= '0;
            hold_cnt         <= '0;
            stall_cnt        <= '0;
            prev_valid       <= 1'b0;
         end else if (state == HOLD) begin
            hold_cnt <= hold_cnt + 16'd1;
         end else if (state == RUN) begin
            if (bus.cycle_count != CNT_MAX)
               bus.cycle_count <= bus.cycle_count + CNT_W'(1);
            if (bus.instr_retire && (bus.retire_count != CNT_MAX))
               bus.retire_count <= bus.retire_count + CNT_W'(1);
            if (stall_cond)
               stall_cnt <= stall_cnt + STALL_W'(1);
            else
               stall_cnt <= '0;
            prev_pc    <= bus.pc;
            prev_valid <= 1'b1;
            if (state_nx == DONE)
               bus.status <= term_code;
         end
      end
   end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: a vector table for the launch/ecall flow
// plus hand-written sequences for stall, timeout, priority, reset and saturation.
module tb_run_controller;

   typedef struct {
      logic        rst;
      logic        start;
      logic [31:0] pc;
      logic        retire;
      logic        ecall;
      logic        expCoreRst;
      logic        expRunning;
      logic        expDone;
      logic [1:0]  expStatus;
      logic [31:0] expCycles;
      logic [31:0] expRetires;
   } vec_t;

   logic clk = 1'b0;
   logic rst1 = 1'b1;
   logic rst2 = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   run_controller_if #(.XLEN(32), .CNT_W(32)) bus1 ();
   run_controller_if #(.XLEN(32), .CNT_W(4))  bus2 ();

   run_controller #(
      .XLEN(32), .CNT_W(32), .RST_HOLD(4), .TIMEOUT(50), .HALT_STABLE(16)
   ) dut (
      .clk(clk),
      .rst(rst1),
      .bus(bus1)
   );

   run_controller #(
      .XLEN(32), .CNT_W(4), .RST_HOLD(1), .TIMEOUT(0), .HALT_STABLE(0)
   ) dutSat (
      .clk(clk),
      .rst(rst2),
      .bus(bus2)
   );

   function automatic vec_t mkVec(input logic r, s, input logic [31:0] p, input logic ir, ec,
                                  input logic cr, run, dn, input logic [1:0] st,
                                  input logic [31:0] cyc, ret);
      vec_t v;
      v.rst = r; v.start = s; v.pc = p; v.retire = ir; v.ecall = ec;
      v.expCoreRst = cr; v.expRunning = run; v.expDone = dn;
      v.expStatus = st; v.expCycles = cyc; v.expRetires = ret;
      return v;
   endfunction

   // Drives one cycle of inputs on the chosen instance, then samples 1 ns after the edge.
   task automatic applyStimulus(input int sel, input logic r, s, input logic [31:0] p,
                                input logic ir, ec);
      if (sel == 0) begin
         rst1 = r; bus1.start = s; bus1.pc = p; bus1.instr_retire = ir; bus1.ecall = ec;
      end else begin
         rst2 = r; bus2.start = s; bus2.pc = p; bus2.instr_retire = ir; bus2.ecall = ec;
      end
      @(posedge clk);
      #1;
      if (sel == 0) begin
         bus1.start = 1'b0; bus1.instr_retire = 1'b0; bus1.ecall = 1'b0;
      end else begin
         bus2.start = 1'b0; bus2.instr_retire = 1'b0; bus2.ecall = 1'b0;
      end
   endtask

   task automatic checkOutput(input int sel, input string name, input logic cr, run, dn,
                              input logic [1:0] st, input logic [31:0] cyc, ret);
      logic        aCr, aRun, aDn;
      logic [1:0]  aSt;
      logic [31:0] aCyc, aRet;
      if (sel == 0) begin
         aCr = bus1.core_rst; aRun = bus1.running; aDn = bus1.done; aSt = bus1.status;
         aCyc = bus1.cycle_count; aRet = bus1.retire_count;
      end else begin
         aCr = bus2.core_rst; aRun = bus2.running; aDn = bus2.done; aSt = bus2.status;
         aCyc = {28'd0, bus2.cycle_count}; aRet = {28'd0, bus2.retire_count};
      end
      checks++;
      if (aCr !== cr || aRun !== run || aDn !== dn || aSt !== st || aCyc !== cyc || aRet !== ret) begin
         errors++;
         $display("[TB] FAIL %s: got core_rst=%0b running=%0b done=%0b status=%0b cycles=%0d retires=%0d, want core_rst=%0b running=%0b done=%0b status=%0b cycles=%0d retires=%0d",
                  name, aCr, aRun, aDn, aSt, aCyc, aRet, cr, run, dn, st, cyc, ret);
      end
   endtask

   task automatic checkValue(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
      end
   endtask

   // Start pulse, then idle through the hold window; the HOLD entry must show cleared counters.
   task automatic launch(input int sel, input int hold, input string name);
      applyStimulus(sel, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      checkOutput(sel, {name, "_hold"}, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
      for (int k = 0; k < hold; k++) applyStimulus(sel, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput(sel, {name, "_run"}, 1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
   endtask

   task automatic runCycles(input int sel, input int n, input logic [31:0] pcBase,
                            input logic [31:0] pcStep, input logic ir, output int ran);
      ran = 0;
      for (int i = 0; i < n; i++) begin
         applyStimulus(sel, 1'b0, 1'b0, pcBase + pcStep * i, ir, 1'b0);
         ran++;
         if ((sel == 0) ? bus1.done : bus2.done) break;
      end
   endtask

   vec_t vecs[20];

   initial begin
      int ran;
      bus1.start = 0; bus1.pc = 0; bus1.instr_retire = 0; bus1.ecall = 0;
      bus2.start = 0; bus2.pc = 0; bus2.instr_retire = 0; bus2.ecall = 0;

      vecs[0] = mkVec(1, 0, 32'h0,  0, 0, 1, 0, 0, 2'b00, 0, 0);
      vecs[1] = mkVec(1, 0, 32'h0,  1, 1, 1, 0, 0, 2'b00, 0, 0);
      vecs[2] = mkVec(1, 1, 32'h0,  0, 0, 1, 0, 0, 2'b00, 0, 0);
      vecs[3] = mkVec(0, 1, 32'h0,  0, 0, 1, 0, 0, 2'b00, 0, 0);
      vecs[4] = mkVec(0, 1, 32'h10, 1, 1, 1, 0, 0, 2'b00, 0, 0);
      vecs[5] = mkVec(0, 0, 32'h0,  0, 0, 1, 0, 0, 2'b00, 0, 0);
      vecs[6] = mkVec(0, 0, 32'h0,  0, 0, 1, 0, 0, 2'b00, 0, 0);
      vecs[7] = mkVec(0, 0, 32'h0,  0, 0, 0, 1, 0, 2'b00, 0, 0);
      for (int i = 8; i < 18; i++)
         vecs[i] = mkVec(0, 0, 32'h100 + 32'(4 * (i - 8)), 1, 0, 0, 1, 0, 2'b00, 32'(i - 7), 32'(i - 7));
      vecs[18] = mkVec(0, 0, 32'h200, 1, 1, 1, 0, 1, 2'b01, 11, 11);
      vecs[19] = mkVec(0, 1 == 0, 32'h300, 1, 1, 1, 0, 1, 2'b01, 11, 11);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, vecs[i].rst, vecs[i].start, vecs[i].pc, vecs[i].retire, vecs[i].ecall);
         checkOutput(0, $sformatf("vec%0d", i), vecs[i].expCoreRst, vecs[i].expRunning,
                     vecs[i].expDone, vecs[i].expStatus, vecs[i].expCycles, vecs[i].expRetires);
      end

      // Constant pc with no retire: first RUN cycle only primes the comparison, then 16 stalled cycles.
      launch(0, 4, "stall");
      runCycles(0, 100, 32'h40, 32'h0, 1'b0, ran);
      checkValue("stall_cycles", ran, 17);
      checkOutput(0, "stall_done", 1, 0, 1, 2'b10, 17, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0, 1'b0, 32'h80 + 32'(i), 1'b1, 1'b1);
      checkOutput(0, "stall_frozen", 1, 0, 1, 2'b10, 17, 0);

      launch(0, 4, "timeout");
      runCycles(0, 9, 32'h1000, 32'h4, 1'b1, ran);
      applyStimulus(0, 1'b0, 1'b1, 32'h2000, 1'b1, 1'b0);
      checkOutput(0, "start_in_run", 0, 1, 0, 2'b00, 10, 10);
      runCycles(0, 200, 32'h3000, 32'h4, 1'b1, ran);
      checkValue("timeout_cycles", ran, 40);
      checkOutput(0, "timeout_done", 1, 0, 1, 2'b11, 50, 50);

      launch(0, 4, "ecall50");
      runCycles(0, 49, 32'h1000, 32'h4, 1'b1, ran);
      checkOutput(0, "ecall50_c49", 0, 1, 0, 2'b00, 49, 49);
      applyStimulus(0, 1'b0, 1'b0, 32'h2000, 1'b1, 1'b1);
      checkOutput(0, "ecall50_done", 1, 0, 1, 2'b01, 50, 50);

      launch(0, 4, "ecall_vs_stall");
      runCycles(0, 16, 32'h40, 32'h0, 1'b0, ran);
      checkOutput(0, "pre_stall", 0, 1, 0, 2'b00, 16, 0);
      applyStimulus(0, 1'b0, 1'b0, 32'h40, 1'b0, 1'b1);
      checkOutput(0, "ecall_beats_stall", 1, 0, 1, 2'b01, 17, 0);

      launch(0, 4, "stall_vs_timeout");
      runCycles(0, 33, 32'h1000, 32'h4, 1'b1, ran);
      runCycles(0, 100, 32'h40, 32'h0, 1'b0, ran);
      checkValue("stall_vs_timeout_cycles", ran, 17);
      checkOutput(0, "stall_beats_timeout", 1, 0, 1, 2'b10, 50, 33);

      // A retire in cycle 10 restarts the stall window, so detection moves out to cycle 26.
      launch(0, 4, "retire_resets_stall");
      runCycles(0, 9, 32'h40, 32'h0, 1'b0, ran);
      applyStimulus(0, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0);
      runCycles(0, 100, 32'h40, 32'h0, 1'b0, ran);
      checkValue("restall_cycles", ran, 16);
      checkOutput(0, "restall_done", 1, 0, 1, 2'b10, 26, 1);

      launch(0, 4, "midrun_rst");
      runCycles(0, 19, 32'h1000, 32'h4, 1'b1, ran);
      checkOutput(0, "midrun_c19", 0, 1, 0, 2'b00, 19, 19);
      applyStimulus(0, 1'b1, 1'b1, 32'h5000, 1'b1, 1'b1);
      checkOutput(0, "midrun_rst_idle", 1, 0, 0, 2'b00, 0, 0);
      applyStimulus(0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput(0, "midhold_rst_idle", 1, 0, 0, 2'b00, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 1'b0, 32'h44 + 32'(i), 1'b1, 1'b1);
      checkOutput(0, "idle_ignores_core", 1, 0, 0, 2'b00, 0, 0);

      // Narrow counters saturate at 15; timeout and stall detection are both disabled here.
      applyStimulus(1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput(1, "sat_reset", 1, 0, 0, 2'b00, 0, 0);
      launch(1, 1, "sat");
      runCycles(1, 18, 32'h80, 32'h4, 1'b1, ran);
      checkValue("sat_ran", ran, 18);
      checkOutput(1, "sat_counts", 0, 1, 0, 2'b00, 15, 15);
      runCycles(1, 20, 32'h80, 32'h0, 1'b0, ran);
      checkValue("no_stall_detect", ran, 20);
      applyStimulus(1, 1'b0, 1'b0, 32'h80, 1'b1, 1'b1);
      checkOutput(1, "sat_ecall", 1, 0, 1, 2'b01, 15, 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter XLEN, 32, width of the observed program counter.
REQ-002 Parameter CNT_W, 32, width of the cycle and retire counters.
REQ-003 Parameter RST_HOLD, 4, cycles core_rst stays asserted after start; legal range 1..2^16-1.
REQ-004 Parameter TIMEOUT, 100000, run-cycle limit; 0 disables the timeout.
REQ-005 Parameter HALT_STABLE, 16, consecutive no-retire cycles with unchanged pc that count as a stall; 0 disables stall detection.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to (re)launch a run.
REQ-009 pc  in  XLEN  core fetch program counter.
REQ-010 instr_retire  in  1  one instruction retired this cycle.
REQ-011 ecall  in  1  core executed an environment call (end-of-program marker).
REQ-012 core_rst  out  1  reset driven to the core under control.
REQ-013 running  out  1  core is executing.
REQ-014 done  out  1  run finished; status is valid.
REQ-015 status  out  2  00 none, 01 ecall, 10 stall, 11 timeout.
REQ-016 cycle_count  out  CNT_W  cycles spent in RUN.
REQ-017 retire_count  out  CNT_W  instructions retired in RUN.

Function
REQ-018 The FSM SHALL have the states IDLE, HOLD, RUN and DONE, and all outputs SHALL be registered.
REQ-019 In IDLE: core_rst=1, running=0, done=0; start SHALL move the FSM to HOLD on the next edge.
REQ-020 On entry to HOLD, cycle_count, retire_count, status, the hold counter and the stall counter SHALL clear.
REQ-021 core_rst SHALL stay 1 for exactly RST_HOLD cycles in HOLD, after which the FSM SHALL enter RUN.
REQ-022 In RUN: core_rst=0, running=1; cycle_count SHALL increment every cycle.
REQ-023 In RUN, retire_count SHALL increment on each cycle with instr_retire=1.
REQ-024 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 Stall counter: it SHALL reset to 0 when instr_retire=1 or when pc differs from the previous cycle's pc; otherwise it SHALL increment.
REQ-026 A stall SHALL be detected when the stall counter reaches HALT_STABLE-1 while the stall condition still holds.
REQ-027 Timeout SHALL be detected in the RUN cycle where cycle_count equals TIMEOUT-1.
REQ-028 Termination priority within one cycle SHALL be ecall > stall > timeout; only the winning code SHALL be latched into status.
REQ-029 On termination, the FSM SHALL enter DONE on the next edge; the terminating cycle SHALL still be counted, including its retire.
REQ-030 In DONE: done=1, running=0, core_rst=1; counters and status SHALL hold; start SHALL re-enter HOLD.
REQ-031 start SHALL be ignored in HOLD and RUN.
REQ-032 ecall, instr_retire and pc SHALL be ignored outside RUN.

Reset
REQ-033 rst=1 SHALL force IDLE on the next edge from any state, including mid-HOLD and mid-RUN.
REQ-034 Reset values: core_rst=1, running=0, done=0, status=00, cycle_count=0, retire_count=0, internal counters 0.
REQ-035 start asserted together with rst SHALL be ignored.

Verification
REQ-036 rst for 2 cycles, then start pulse with RST_HOLD=4 -> core_rst=1 for exactly 4 cycles after the FSM leaves IDLE, then running=1.
REQ-037 RUN with retire every cycle for 10 cycles, then ecall together with a retire -> done=1 next cycle, status=01, cycle_count=11, retire_count=11.
REQ-038 HALT_STABLE=16, pc held at 0x40 with no retire -> status=10 after 16 stalled cycles; counts frozen in DONE.
REQ-039 TIMEOUT=50, continuous retire with changing pc -> status=11, cycle_count=50; an ecall in cycle 50 instead yields status=01.
REQ-040 rst asserted mid-RUN at cycle 20 -> IDLE next cycle with all reset values; start in DONE -> counters cleared and core_rst reasserted.
